// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection light sequencer with all-red clearance,
// pedestrian walk insertion and a freezable phase timer.
module traffic_intersection_ctrl #(
  parameter int CNT_W       = 8,
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 4,
  parameter int RED_TIME    = 2,
  parameter int WALK_TIME   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       hold,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR_NS   = 3'd0,
    NS_G    = 3'd1,
    NS_Y    = 3'd2,
    AR_EW   = 3'd3,
    EW_G    = 3'd4,
    EW_Y    = 3'd5,
    WALK_NS = 3'd6,
    WALK_EW = 3'd7
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [CNT_W-1:0] LD_G = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] LD_Y = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] LD_R = CNT_W'(RED_TIME - 1);
  localparam logic [CNT_W-1:0] LD_W = CNT_W'(WALK_TIME - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             pend_nx;
  logic             expire;
  logic             in_walk;
  logic             to_walk;

  assign expire  = (cnt == '0) && !hold;
  assign in_walk = (state == WALK_NS) || (state == WALK_EW);
  assign to_walk = expire &&
                   ((state_nx == WALK_NS) || (state_nx == WALK_EW));

  always_comb begin
    state_nx = state;
    if (expire) begin
      unique case (state)
        AR_NS:   state_nx = ped_pending ? WALK_NS : NS_G;
        NS_G:    state_nx = NS_Y;
        NS_Y:    state_nx = AR_EW;
        AR_EW:   state_nx = ped_pending ? WALK_EW : EW_G;
        EW_G:    state_nx = EW_Y;
        EW_Y:    state_nx = AR_NS;
        WALK_NS: state_nx = NS_G;
        WALK_EW: state_nx = EW_G;
        default: state_nx = AR_NS;
      endcase
    end
  end

  always_comb begin
    cnt_nx = cnt;
    if (expire) begin
      unique case (state_nx)
        NS_G, EW_G:       cnt_nx = LD_G;
        NS_Y, EW_Y:       cnt_nx = LD_Y;
        WALK_NS, WALK_EW: cnt_nx = LD_W;
        default:          cnt_nx = LD_R;
      endcase
    end else if (!hold) begin
      cnt_nx = cnt - CNT_W'(1);
    end
  end

  // Walk entry clears the latch; requests during a walk are dropped.
  always_comb begin
    pend_nx = ped_pending;
    if (to_walk)
      pend_nx = 1'b0;
    else if (!in_walk && ped_req)
      pend_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= AR_NS;
      cnt         <= LD_R;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ped_pending <= pend_nx;
    end
  end

  always_comb begin
    ns_light = RED;
    ew_light = RED;
    unique case (1'b1)
      (state == NS_G): ns_light = GREEN;
      (state == NS_Y): ns_light = YELLOW;
      (state == EW_G): ew_light = GREEN;
      (state == EW_Y): ew_light = YELLOW;
      default: ;
    endcase
  end

  assign walk  = in_walk;
  assign phase = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Randomized scoreboard bench for traffic_intersection_ctrl against
// a cycle-level phase/elapsed-time reference model.
module tb_traffic_intersection_ctrl;

  localparam int G = 4;
  localparam int Y = 2;
  localparam int R = 1;
  localparam int W = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_req = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  traffic_intersection_ctrl #(
    .CNT_W(8), .GREEN_TIME(G), .YELLOW_TIME(Y),
    .RED_TIME(R), .WALK_TIME(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .hold(hold),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    bit pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   mph;
  int   mel;
  bit   mpend;

  function automatic int dur(int p);
    case (p)
      1, 4:    return G;
      2, 5:    return Y;
      6, 7:    return W;
      default: return R;
    endcase
  endfunction

  function automatic int nxt(int p, bit pend);
    case (p)
      0:       return pend ? 6 : 1;
      1:       return 2;
      2:       return 3;
      3:       return pend ? 7 : 4;
      4:       return 5;
      5:       return 0;
      6:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int ns_of(int p);
    return (p == 1) ? 1 : (p == 2) ? 2 : 4;
  endfunction

  function automatic int ew_of(int p);
    return (p == 4) ? 1 : (p == 5) ? 2 : 4;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, req, $time);
  endtask

  task automatic mreset();
    mph = 0;
    mel = 0;
    mpend = 1'b0;
  endtask

  task automatic mstep(bit p, bit h);
    int old;
    old = mph;
    if (!h) begin
      if (mel + 1 >= dur(mph)) begin
        mph = nxt(mph, mpend);
        mel = 0;
      end else begin
        mel++;
      end
    end
    if (mph != old && (mph == 6 || mph == 7)) mpend = 1'b0;
    else if (old != 6 && old != 7 && p) mpend = 1'b1;
  endtask

  task automatic push();
    exp_t e;
    e.ph = mph;
    e.pend = mpend;
    q.push_back(e);
  endtask

  task automatic cyc(bit p, bit h);
    ped_req = p;
    hold = h;
    @(posedge clk);
    #1;
    mstep(p, h);
    push();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("phase", int'(phase), e.ph);
      check("ns_light", int'(ns_light), ns_of(e.ph));
      check("ew_light", int'(ew_light), ew_of(e.ph));
      check("walk", int'(walk), int'(e.ph >= 6));
      check("ped_pending", int'(ped_pending), int'(e.pend));
      check("both_go", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
    end
  end

  task automatic random_run(int n);
    int hl;
    bit p;
    bit h;
    hl = 0;
    for (int i = 0; i < n; i++) begin
      p = ($urandom % 10) == 0;
      if (hl > 0) begin
        h = 1'b1;
        hl--;
      end else begin
        h = 1'b0;
        if (($urandom % 16) == 0) hl = $urandom_range(1, 6);
      end
      cyc(p, h);
    end
  endtask

  initial begin
    int n;
    mreset();
    repeat (2) begin
      @(posedge clk);
      #1;
      push();
    end
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);
    random_run(1500);

    n = 0;
    while (!(mph == 4 && mpend) && n < 100) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    check("reach_ewg_pending", int'(mph == 4 && mpend), 1);
    ped_req = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_phase", int'(phase), 0);
    check("async_ns", int'(ns_light), 4);
    check("async_ew", int'(ew_light), 4);
    check("async_walk", int'(walk), 0);
    check("async_pend", int'(ped_pending), 0);
    mreset();
    @(posedge clk);
    #1;
    push();
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    check("ns_green_after_reset", int'(mph), 1);

    random_run(1000);
    @(negedge clk);
    #1;
    if (q.size() != 0) check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
